// File: rtl/wifi_pkt_pkg.sv
// wifi_pkt_pkg
//   Shared constants and state encodings for the WiFi bounding-box UART
//   receiver: default sync marker, payload length, and the RX / parser
//   state enums.
package wifi_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         PAYLOAD_BYTES     = 6;

    typedef enum logic [1:0] {
        PS_HUNT,
        PS_PAYLOAD,
        PS_CHECK
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1
//   8N1 UART byte receiver with a 2-flop input synchroniser. Bits are
//   sampled mid-bit using a down-counter that reloads every bit time.
//
//   Ports
//     clk_clk      in   system clock
//     reset_reset  in   synchronous active-high reset
//     rxd          in   asynchronous serial input, idle high
//     byte_valid   out  1-cycle pulse, byte_data holds a good byte
//     byte_ferr    out  1-cycle pulse, stop bit was 0 (byte dropped)
//     byte_data    out  last assembled byte
//
//   state    | meaning
//   ---------+------------------------------------------------
//   RX_IDLE  | waiting for a falling edge on the synced line
//   RX_START | half a bit in, confirm start bit is still low
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling stop bit, then back to idle
module uart_rx_8n1
    import wifi_pkt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       rxd,
    output logic       byte_valid,
    output logic       byte_ferr,
    output logic [7:0] byte_data
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rxd_meta;
    logic             rxd_sync;
    logic             rxd_prev;

    assign byte_data = shift;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rxd_meta   <= 1'b1;
            rxd_sync   <= 1'b1;
            rxd_prev   <= 1'b1;
            byte_valid <= 1'b0;
            byte_ferr  <= 1'b0;
        end else begin
            rxd_meta   <= rxd;
            rxd_sync   <= rxd_meta;
            rxd_prev   <= rxd_sync;
            byte_valid <= 1'b0;
            byte_ferr  <= 1'b0;

            case (state)
                RX_IDLE: begin
                    // Edge rather than level: after a framing error the line
                    // may still be low and must not retrigger.
                    if (rxd_prev && !rxd_sync) begin
                        state <= RX_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        if (rxd_sync) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            cnt     <= BIT_LOAD;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        shift <= {rxd_sync, shift[7:1]};
                        cnt   <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        byte_valid <= rxd_sync;
                        byte_ferr  <= ~rxd_sync;
                        state      <= RX_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wifi_bbox_uart_rx.sv
// wifi_bbox_uart_rx
//   Receives fixed-length bounding-box packets (sync, 6 payload bytes,
//   XOR checksum) from the WiFi module and holds the last good box.
//
//   Ports
//     clk_clk      in   system clock
//     reset_reset  in   synchronous active-high reset
//     rx_en        in   1 = ready for data (drives uart_rts_n only)
//     uart_rxd     in   serial input, idle high
//     uart_rts_n   out  registered ~rx_en
//     bbox_x/y/w/h out  12-bit fields of the last good packet
//     frame_valid  out  1-cycle pulse when bbox_* update
//     frame_err    out  1-cycle pulse on checksum/framing/timeout error
//     err_count    out  saturating count of frame_err pulses
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   PS_HUNT    | discarding bytes until the sync marker
//   PS_PAYLOAD | collecting 6 payload bytes, gap timer running
//   PS_CHECK   | waiting for checksum byte, gap timer running
module wifi_bbox_uart_rx
    import wifi_pkt_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        rx_en,
    input  logic        uart_rxd,
    output logic        uart_rts_n,
    output logic [11:0] bbox_x,
    output logic [11:0] bbox_y,
    output logic [11:0] bbox_w,
    output logic [11:0] bbox_h,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    localparam int               TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int               TO_W      = $clog2(TO_CYCLES);
    localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TO_CYCLES - 1);
    localparam int               IDX_W     = $clog2(PAYLOAD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_BYTES - 1);

    logic                         byte_valid;
    logic                         byte_ferr;
    logic [7:0]                   byte_data;

    parser_state_t                pstate;
    logic [8*PAYLOAD_BYTES-1:0]   payload;
    logic [7:0]                   acc;
    logic [IDX_W-1:0]             byte_idx;
    logic [TO_W-1:0]              to_cnt;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .rxd         (uart_rxd),
        .byte_valid  (byte_valid),
        .byte_ferr   (byte_ferr),
        .byte_data   (byte_data)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pstate      <= PS_HUNT;
            payload     <= '0;
            acc         <= '0;
            byte_idx    <= '0;
            to_cnt      <= TO_LOAD;
            bbox_x      <= '0;
            bbox_y      <= '0;
            bbox_w      <= '0;
            bbox_h      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
            uart_rts_n  <= 1'b1;
        end else begin
            uart_rts_n  <= ~rx_en;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            // Counts the pulse issued on the previous cycle.
            if (frame_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 1'b1;
            end

            case (pstate)
                PS_HUNT: begin
                    if (byte_valid && (byte_data == SYNC_BYTE)) begin
                        pstate   <= PS_PAYLOAD;
                        acc      <= '0;
                        byte_idx <= '0;
                        to_cnt   <= TO_LOAD;
                    end else if (byte_ferr) begin
                        frame_err <= 1'b1;
                    end
                end
                PS_PAYLOAD: begin
                    if (byte_valid) begin
                        payload <= {payload[8*PAYLOAD_BYTES-9:0], byte_data};
                        acc     <= acc ^ byte_data;
                        to_cnt  <= TO_LOAD;
                        if (byte_idx == LAST_IDX) begin
                            pstate <= PS_CHECK;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end else if (byte_ferr || (to_cnt == '0)) begin
                        frame_err <= 1'b1;
                        pstate    <= PS_HUNT;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                PS_CHECK: begin
                    if (byte_valid) begin
                        if (byte_data == acc) begin
                            bbox_x      <= payload[47:36];
                            bbox_y      <= payload[35:24];
                            bbox_w      <= payload[23:12];
                            bbox_h      <= payload[11:0];
                            frame_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        pstate <= PS_HUNT;
                    end else if (byte_ferr || (to_cnt == '0)) begin
                        frame_err <= 1'b1;
                        pstate    <= PS_HUNT;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                default: pstate <= PS_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_wifi_bbox_uart_rx.sv
// tb_wifi_bbox_uart_rx
//   Directed bench: expected frame events are queued as packets are sent and
//   checked by a monitor when frame_valid / frame_err pulse.
module tb_wifi_bbox_uart_rx;

    localparam int CPB = 8;
    localparam int TOB = 20;
    localparam logic [63:0] PKT1 = 64'hA5_12_34_56_78_9A_BC_2E;

    logic        clk_clk     = 1'b0;
    logic        reset_reset = 1'b1;
    logic        rx_en       = 1'b0;
    logic        uart_rxd    = 1'b1;
    logic        uart_rts_n;
    logic [11:0] bbox_x, bbox_y, bbox_w, bbox_h;
    logic        frame_valid, frame_err;
    logic [7:0]  err_count;

    typedef struct {
        bit          err;
        logic [11:0] x, y, w, h;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_stop_cyc = 0;
    int          exp_err = 0;
    logic [11:0] last_x = '0, last_y = '0, last_w = '0, last_h = '0;

    wifi_bbox_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .rx_en       (rx_en),
        .uart_rxd    (uart_rxd),
        .uart_rts_n  (uart_rts_n),
        .bbox_x      (bbox_x),
        .bbox_y      (bbox_y),
        .bbox_w      (bbox_w),
        .bbox_h      (bbox_h),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_count   (err_count)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_valid(input logic [11:0] x, input logic [11:0] y,
                              input logic [11:0] w, input logic [11:0] h);
        sb.push_back('{err: 1'b0, x: x, y: y, w: w, h: h});
    endtask

    task automatic push_err();
        sb.push_back('{err: 1'b1, x: 12'h0, y: 12'h0, w: 12'h0, h: 12'h0});
    endtask

    task automatic drive_bit(input logic v);
        @(posedge clk_clk);
        #1 uart_rxd = v;
        repeat (CPB - 1) @(posedge clk_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        @(posedge clk_clk);
        #1 uart_rxd = stop;
        last_stop_cyc = cyc;
        repeat (CPB - 1) @(posedge clk_clk);
        drive_bit(1'b1);
    endtask

    task automatic send_pkt(input logic [63:0] pkt);
        for (int i = 0; i < 8; i++) send_byte(pkt[63-8*i -: 8], 1'b1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(posedge clk_clk);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk_clk);
        repeat (3) @(negedge clk_clk);
        check(tag, 32'(sb.size()), 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk_clk) begin
        exp_t e;
        int   delta;
        if (!reset_reset && (frame_valid || frame_err)) begin
            check("pulse_exclusive", 32'(frame_valid & frame_err), 0);
            check("pulse_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pulse_kind", 32'(frame_err), 32'(e.err));
                if (!e.err) begin
                    check("bbox_x", 32'(bbox_x), 32'(e.x));
                    check("bbox_y", 32'(bbox_y), 32'(e.y));
                    check("bbox_w", 32'(bbox_w), 32'(e.w));
                    check("bbox_h", 32'(bbox_h), 32'(e.h));
                    delta = cyc - last_stop_cyc;
                    check("latency_window",
                          32'((delta >= CPB/2 + 2) && (delta <= CPB/2 + 6)), 1);
                    last_x = e.x; last_y = e.y; last_w = e.w; last_h = e.h;
                end else begin
                    check("hold_x", 32'(bbox_x), 32'(last_x));
                    check("hold_y", 32'(bbox_y), 32'(last_y));
                    check("hold_w", 32'(bbox_w), 32'(last_w));
                    check("hold_h", 32'(bbox_h), 32'(last_h));
                    if (exp_err < 255) exp_err++;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (5) @(posedge clk_clk);
        @(negedge clk_clk);
        check("rst_rts_n", 32'(uart_rts_n), 1);
        check("rst_bbox", 32'({bbox_x, bbox_y} | {bbox_w, bbox_h}), 0);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_err_count", 32'(err_count), 0);
        @(posedge clk_clk);
        #1 reset_reset = 1'b0;
        idle_bits(3);

        // 1: good packet
        push_valid(12'h123, 12'h456, 12'h789, 12'hABC);
        send_pkt(PKT1);
        wait_drain("t1_drain");
        check("t1_err_count", 32'(err_count), 0);

        // 2: bad checksum, then good packet
        push_err();
        send_pkt(64'hA5_12_34_56_78_9A_BC_2F);
        wait_drain("t2_drain_bad");
        check("t2_err_count", 32'(err_count), 32'(exp_err));
        check("t2_err_count_one", 32'(err_count), 1);
        push_valid(12'h123, 12'h456, 12'h789, 12'hABC);
        send_pkt(PKT1);
        wait_drain("t2_drain_good");

        // 3: noise in HUNT, good packet, sync values as payload data
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        push_valid(12'h123, 12'h456, 12'h789, 12'hABC);
        send_pkt(PKT1);
        wait_drain("t3_drain_noise");
        push_valid(12'hA5A, 12'h5A5, 12'hA5A, 12'h5A5);
        send_pkt(64'hA5_A5_A5_A5_A5_A5_A5_00);
        wait_drain("t3_drain_sync_data");
        check("t3_err_count", 32'(err_count), 1);

        // 4: inter-byte timeout, then good packet
        push_err();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle_bits(161);
        wait_drain("t4_drain_timeout");
        check("t4_err_count", 32'(err_count), 32'(exp_err));
        push_valid(12'h123, 12'h456, 12'h789, 12'hABC);
        send_pkt(PKT1);
        wait_drain("t4_drain_good");

        // 4: 2-cycle glitch inside a packet must not create a byte
        push_valid(12'h123, 12'h456, 12'h789, 12'hABC);
        for (int i = 0; i < 6; i++) send_byte(PKT1[63-8*i -: 8], 1'b1);
        @(posedge clk_clk);
        #1 uart_rxd = 1'b0;
        @(posedge clk_clk);
        @(posedge clk_clk);
        #1 uart_rxd = 1'b1;
        idle_bits(3);
        send_byte(8'hBC, 1'b1);
        send_byte(8'h2E, 1'b1);
        wait_drain("t4_drain_glitch");
        check("t4_glitch_err_count", 32'(err_count), 32'(exp_err));

        // 5: framing error on 3rd byte, then saturation of err_count
        push_err();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        wait_drain("t5_drain_ferr");
        check("t5_err_count", 32'(err_count), 32'(exp_err));
        push_valid(12'h123, 12'h456, 12'h789, 12'hABC);
        send_pkt(PKT1);
        wait_drain("t5_drain_good");
        for (int i = 0; i < 260; i++) begin
            push_err();
            send_byte(8'h00, 1'b0);
        end
        wait_drain("t5_drain_sat");
        check("t5_err_count_sat", 32'(err_count), 255);
        check("t5_model_sat", 32'(exp_err), 255);

        // 6: rx_en -> uart_rts_n
        @(posedge clk_clk);
        #1 rx_en = 1'b1;
        @(negedge clk_clk);
        check("t6_rts_before_edge", 32'(uart_rts_n), 1);
        @(negedge clk_clk);
        check("t6_rts_low", 32'(uart_rts_n), 0);
        @(posedge clk_clk);
        #1 rx_en = 1'b0;
        @(negedge clk_clk);
        @(negedge clk_clk);
        check("t6_rts_high", 32'(uart_rts_n), 1);
        @(posedge clk_clk);
        #1 rx_en = 1'b1;

        // 6: reset mid-packet
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #1 reset_reset = 1'b1;
        uart_rxd = 1'b1;
        sb.delete();
        repeat (4) @(posedge clk_clk);
        @(negedge clk_clk);
        check("t6_rst_bbox_x", 32'(bbox_x), 0);
        check("t6_rst_bbox_y", 32'(bbox_y), 0);
        check("t6_rst_bbox_w", 32'(bbox_w), 0);
        check("t6_rst_bbox_h", 32'(bbox_h), 0);
        check("t6_rst_err_count", 32'(err_count), 0);
        check("t6_rst_pulses", 32'({frame_valid, frame_err}), 0);
        check("t6_rst_rts_n", 32'(uart_rts_n), 1);
        exp_err = 0;
        last_x = '0; last_y = '0; last_w = '0; last_h = '0;
        @(posedge clk_clk);
        #1 reset_reset = 1'b0;
        @(negedge clk_clk);
        @(negedge clk_clk);
        check("t6_rts_after_rst", 32'(uart_rts_n), 0);
        idle_bits(3);
        push_valid(12'h123, 12'h456, 12'h789, 12'hABC);
        send_pkt(PKT1);
        wait_drain("t6_drain_good");
        check("t6_err_count_final", 32'(err_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
